// File: rtl/avalon_blockram_arb_pkg.sv
// Shared types and default sizes for the two-port Avalon block-RAM arbiter.
package avalon_blockram_arb_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    // Enum values double as bit indices into the two-bit request/grant vectors.
    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_id_e;
endpackage

// File: rtl/bram_rr_arb2.sv
// Two-request arbiter with a one-hot grant. Round-robin by default;
// BRAM_ARB_DPRIO_EN gives the data port fixed priority instead.
module bram_rr_arb2
    import avalon_blockram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] grant
);

`ifdef BRAM_ARB_DPRIO_EN
    logic unused_clk;
    assign unused_clk = clk ^ reset_n;

    always_comb begin
        grant = 2'b00;
        if (req[PORT_D])
            grant[PORT_D] = 1'b1;
        else if (req[PORT_I])
            grant[PORT_I] = 1'b1;
    end
`else
    port_id_e last_grant;

    // On contention the port that did not win most recently goes first.
    always_comb begin
        grant = req;
        if (req == 2'b11)
            grant = (last_grant == PORT_D) ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last_grant <= PORT_D;
        else if (grant[PORT_D])
            last_grant <= PORT_D;
        else if (grant[PORT_I])
            last_grant <= PORT_I;
    end
`endif

endmodule

// File: rtl/avalon_blockram_arbiter.sv
// Shares one 1-cycle-latency block RAM between an instruction and a data Avalon-MM port.
// Define BRAM_ARB_DPRIO_EN for fixed data-port priority instead of round-robin.
module avalon_blockram_arbiter
    import avalon_blockram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic                i_read,
    input  logic [ADDR_W-1:0]   i_address,
    output logic                i_waitrequest,
    output logic [DATA_W-1:0]   i_readdata,
    output logic                i_readdatavalid,

    input  logic                d_read,
    input  logic                d_write,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic [DATA_W/8-1:0] d_byteenable,
    input  logic [DATA_W-1:0]   d_writedata,
    output logic                d_waitrequest,
    output logic [DATA_W-1:0]   d_readdata,
    output logic                d_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    logic [1:0]        req;
    logic [1:0]        grant;
    logic              d_req;
    logic              rd_issue;
    logic              rd_pend;
    port_id_e          rd_owner;
    logic [ADDR_W-1:0] addr_q;

    assign d_req = d_read | d_write;
    // Requests are masked in reset so nothing reaches the RAM.
    assign req   = {d_req, i_read} & {2{reset_n}};

    bram_rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .grant   (grant)
    );

    assign i_waitrequest = ~reset_n | (i_read & ~grant[PORT_I]);
    assign d_waitrequest = ~reset_n | (d_req  & ~grant[PORT_D]);

    assign mem_chipselect = |grant;
    assign mem_write      = grant[PORT_D] & d_write;
    assign mem_byteenable = grant[PORT_D] ? d_byteenable : '1;
    assign mem_writedata  = d_writedata;
    assign mem_clken      = reset_n;
    assign mem_address    = grant[PORT_D] ? d_address :
                            grant[PORT_I] ? i_address : addr_q;

    // A simultaneous read+write on the data port is a write only.
    assign rd_issue = grant[PORT_I] | (grant[PORT_D] & d_read & ~d_write);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend  <= 1'b0;
            rd_owner <= PORT_D;
            addr_q   <= '0;
        end else begin
            rd_pend <= rd_issue;
            if (rd_issue)
                rd_owner <= grant[PORT_I] ? PORT_I : PORT_D;
            if (mem_chipselect)
                addr_q <= mem_address;
        end
    end

    assign i_readdatavalid = rd_pend & (rd_owner == PORT_I);
    assign d_readdatavalid = rd_pend & (rd_owner == PORT_D);
    assign i_readdata      = mem_readdata;
    assign d_readdata      = mem_readdata;

endmodule

// File: doc/avalon_blockram_arbiter.md
AVALON_BLOCKRAM_ARBITER -- requirements
Module: avalon_blockram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, word-address width of the shared RAM.
REQ-002 The block SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 The block SHALL have port clk, input, 1: single clock for all logic.
REQ-004 The block SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port i_read, input, 1: instruction-port read request.
REQ-006 The block SHALL have port i_address, input, ADDR_W: instruction-port word address.
REQ-007 The block SHALL have port i_waitrequest, output, 1: instruction request not accepted this cycle.
REQ-008 The block SHALL have port i_readdata, output, DATA_W: instruction read data.
REQ-009 The block SHALL have port i_readdatavalid, output, 1: i_readdata valid.
REQ-010 The block SHALL have port d_read, input, 1: data-port read request.
REQ-011 The block SHALL have port d_write, input, 1: data-port write request.
REQ-012 The block SHALL have port d_address, input, ADDR_W: data-port word address.
REQ-013 The block SHALL have port d_byteenable, input, DATA_W/8: data-port write byte lanes.
REQ-014 The block SHALL have port d_writedata, input, DATA_W: data-port write data.
REQ-015 The block SHALL have ports d_waitrequest (output, 1), d_readdata (output, DATA_W) and d_readdatavalid (output, 1), mirroring the instruction port.
REQ-016 The block SHALL have memory-side outputs mem_address (ADDR_W), mem_byteenable (DATA_W/8), mem_chipselect (1), mem_write (1), mem_writedata (DATA_W) and mem_clken (1), plus input mem_readdata (DATA_W); the RAM has 1-cycle read latency.

Function
REQ-017 At most one access SHALL be issued to the memory per cycle, with mem_chipselect=1 in that cycle.
REQ-018 A request SHALL be accepted in the same cycle it is granted, with waitrequest = request & ~grant and no registered delay.
REQ-019 With a single requester, that requester SHALL be granted immediately.
REQ-020 With both requesting, grant SHALL go to the port not granted most recently (round-robin); last_grant resets to DATA, so the instruction port wins the first contention.
REQ-021 The d_read/d_write/d_address/d_byteenable/d_writedata signals SHALL be forwarded unchanged when the data port is granted.
REQ-022 For instruction reads, mem_byteenable SHALL be all-ones and mem_write=0.
REQ-023 If d_read and d_write are both 1, the access SHALL be treated as a write and d_readdatavalid SHALL NOT assert.
REQ-024 A pending-read register (rd_pend, rd_owner) SHALL be loaded on each issued read.
REQ-025 Exactly one cycle after an issued read, the owner's readdatavalid SHALL be 1 and its readdata SHALL equal mem_readdata; the other port's readdatavalid SHALL be 0.
REQ-026 Back-to-back reads SHALL sustain 1 access per cycle, including alternating owners.
REQ-027 Writes SHALL produce no readdatavalid.
REQ-028 mem_clken SHALL be 1 whenever reset_n=1.
REQ-029 When idle (no grant), mem_chipselect=0 and mem_write=0, and mem_address SHALL hold its last value.

Reset
REQ-030 On reset_n=0, the following SHALL clear asynchronously: rd_pend=0, last_grant=DATA, both readdatavalid=0, mem_chipselect=0, mem_write=0, mem_clken=0.
REQ-031 A read in flight at reset assertion SHALL be dropped, and no readdatavalid SHALL appear after reset release.
REQ-032 Both waitrequest outputs SHALL be 1 while reset_n=0.

Configuration
REQ-033 With BRAM_ARB_DPRIO_EN defined, the data port SHALL have fixed priority on contention and last_grant logic SHALL be removed.
REQ-034 Without BRAM_ARB_DPRIO_EN, round-robin per REQ-020 SHALL apply.

Structure
REQ-035 Package avalon_blockram_arb_pkg SHALL hold the port_id_e enum (PORT_I, PORT_D) and default ADDR_W/DATA_W constants.
REQ-036 The grant logic SHALL be the sub-module bram_rr_arb2: two requests in, one-hot grant out, with the last_grant register inside.

Verification
REQ-037 Single-port read: i_read=1, i_address=0x10, RAM[0x10]=0xDEADBEEF -> i_waitrequest=0; one cycle later i_readdatavalid=1 and i_readdata=0xDEADBEEF.
REQ-038 Contention: i_read and d_read held for 4 cycles -> grants I,D,I,D; readdatavalid alternates one cycle later each time.
REQ-039 Byte write: d_write=1, d_address=0x05, d_byteenable=4'b0010, d_writedata=0x0000AB00 over 0x11223344 -> readback 0x1122AB44.
REQ-040 Read/write collision: d_read=d_write=1 -> write performed and d_readdatavalid stays 0.
REQ-041 Reset mid-read: issue an i_read, assert reset_n=0 the next edge -> i_readdatavalid=0 throughout and after release.
REQ-042 BRAM_ARB_DPRIO_EN build: continuous contention for 4 cycles -> data port granted in all 4 and i_waitrequest=1 throughout.
